mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client arbiter in front of the external memory port. It merges the instruction-cache refill client (client 0) and the data-cache refill/writeback client (client 1) onto the single memory request, write-data and read-response channels. It serialises transactions, forwards write data for the granted client, and steers the 4-beat read bursts back by tag.

## Interface
- DATA_CYCLES, 4: read response beats per read request.
- CID_BITS, 1: client-id bits prepended to the memory tag (fixed at 1 for two clients).
- Widths come from the shared `MEM_ADDR_BITS`, `MEM_DATA_BITS`, `MEM_TAG_BITS` defines. Client tags are `MEM_TAG_BITS`-1 wide.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- cN_req_valid (N=0,1)  in  1  client address request valid; held until accepted
- cN_req_ready  out  1  client address request accepted this cycle
- cN_req_rw  in  1  1 = write, 0 = read
- cN_req_addr  in  MEM_ADDR_BITS  128-bit-word address
- cN_req_tag  in  MEM_TAG_BITS-1  client tag
- cN_req_data_valid  in  1  write data valid
- cN_req_data_ready  out  1  write data accepted
- cN_req_data_bits  in  MEM_DATA_BITS  write data
- cN_req_data_mask  in  MEM_DATA_BITS/8  byte enables
- cN_resp_valid  out  1  read beat for this client; no backpressure
- cN_resp_data  out  MEM_DATA_BITS  read beat data
- cN_resp_tag  out  MEM_TAG_BITS-1  client tag of beat
- mem_req_valid/ready/rw/addr/tag  out/in/out/out/out  1/1/1/MEM_ADDR_BITS/MEM_TAG_BITS  memory address channel; tag = {client id, client tag}
- mem_req_data_valid/ready/bits/mask  out/in/out/out  1/1/MEM_DATA_BITS/MEM_DATA_BITS/8  memory write-data channel
- mem_resp_valid/data/tag  in  1/MEM_DATA_BITS/MEM_TAG_BITS  memory read beats

## Operation
- States: IDLE, WDATA, RD.
- IDLE: `mem_req_valid` = c0_req_valid | c1_req_valid. The selected client's rw/addr/tag are muxed onto memory, with tag msb = client id. `cN_req_ready` = mem_req_ready & selected==N.
- Selection: round-robin. Pointer `last` is updated only on an address handshake. With both valid, the client != last wins. With one valid, that client wins. Selection stays stable while mem_req_ready is low.
- IDLE -> WDATA on write handshake; owner := winner.
- IDLE -> RD on read handshake; owner := winner; beat count := 0.
- WDATA: the owner's data valid/bits/mask drive the memory data channel. `owner_data_ready` = mem_req_data_ready. The non-owner's data_ready = 0. Data presented in IDLE/RD is not forwarded. WDATA -> IDLE on data handshake.
- RD: count each mem_resp_valid beat. RD -> IDLE on the DATA_CYCLES-th beat. No new request is presented in WDATA or RD (mem_req_valid = 0).
- Response steering, in any state: `cN_resp_valid` = mem_resp_valid & (mem_resp_tag msb == N). Data and low tag bits pass through to both clients.
- Beat counter is `ceilLog2(DATA_CYCLES)` bits wide and wraps to 0 on the final beat.

## Timing
- Address path is combinational: client valid -> mem_req_valid in the same cycle.
- State changes the cycle after a handshake. The earliest write-data transfer is 1 cycle after the address handshake.
- Responses: 0-cycle pass-through.
- Back-to-back: after the final read beat or the data handshake, the next request can be presented on the following cycle.
- Reset, including mid-transaction: state := IDLE, count := 0, last := 1 (client 0 preferred first), owner := 0.
- Reset outputs: mem_req_valid, mem_req_data_valid, all cN_req_ready, cN_req_data_ready and cN_resp_valid are 0 while reset is asserted.
- In-flight memory beats arriving after reset are ignored by the FSM but still steered by tag.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: client 1 (dcache) always wins when both are valid. `last` is unused.
  - Undefined: round-robin as above.

## Structure
- Shared package/header holds the state encoding (IDLE/WDATA/RD), DATA_CYCLES default, and CID_BITS/client-id constants.
- One sub-module: `mem_arb_rr2`, the 2-way round-robin picker (valids, last, fixed-prio option -> grant).

## Test plan
- c0 read, addr 0x40, tag 5 -> mem_req_tag = {0,5}; 4 beats arrive with tag {0,5} -> c0_resp_valid ×4 with tag 5; c1_resp_valid stays 0; back to IDLE.
- Both valid reads after reset -> c0 granted; c1 granted the cycle after c0's 4th beat. Repeat -> c0 again. With `MEM_ARB_FIXED_PRIO_EN`, c1 is granted first each time.
- c1 write, addr 0x100, data 0x0123…CDEF, mask 0x00FF -> mem sees rw=1, tag msb 1, then data/mask forwarded in WDATA; c0_req_data_ready stays 0.
- mem_req_ready = 0 for 3 cycles with c0 and c1 valid -> no cN_req_ready; addr/tag stable; grant on the first ready cycle.
- Reset asserted after the 2nd read beat -> next cycle IDLE, all valid/ready outputs 0; new c1 read after reset accepted immediately.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-client memory arbiter: FSM state encoding,
// default read burst length, client-id width and the client ids themselves.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;

  localparam int DATA_CYCLES_DEF = 4;

  localparam int   CID_BITS   = 1;
  localparam logic CID_ICACHE = 1'b0;
  localparam logic CID_DCACHE = 1'b1;

  // Never returns 0, so a counter for a 1-beat burst still has a bit.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way request picker: round-robin on 'last' by default, or fixed
// priority to the dcache client when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = CID_ICACHE;
    if (valid1)
      grant = CID_DCACHE;
  end
`else
  // On contention, the client that did not win the last handshake goes next.
  always_comb begin
    grant = CID_ICACHE;
    if (valid0 && valid1)
      grant = ~last;
    else if (valid1)
      grant = CID_DCACHE;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter merging the icache (client 0) and dcache (client 1) onto one memory
// port; read beats are steered back by tag msb. Option: MEM_ARB_FIXED_PRIO_EN.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_CYCLES = DATA_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          c0_req_valid,
  output logic                          c0_req_ready,
  input  logic                          c0_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]     c0_req_addr,
  input  logic [`MEM_TAG_BITS-2:0]      c0_req_tag,
  input  logic                          c0_req_data_valid,
  output logic                          c0_req_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]     c0_req_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0]   c0_req_data_mask,
  output logic                          c0_resp_valid,
  output logic [`MEM_DATA_BITS-1:0]     c0_resp_data,
  output logic [`MEM_TAG_BITS-2:0]      c0_resp_tag,

  input  logic                          c1_req_valid,
  output logic                          c1_req_ready,
  input  logic                          c1_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]     c1_req_addr,
  input  logic [`MEM_TAG_BITS-2:0]      c1_req_tag,
  input  logic                          c1_req_data_valid,
  output logic                          c1_req_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]     c1_req_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0]   c1_req_data_mask,
  output logic                          c1_resp_valid,
  output logic [`MEM_DATA_BITS-1:0]     c1_resp_data,
  output logic [`MEM_TAG_BITS-2:0]      c1_resp_tag,

  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_rw,
  output logic [`MEM_ADDR_BITS-1:0]     mem_req_addr,
  output logic [`MEM_TAG_BITS-1:0]      mem_req_tag,
  output logic                          mem_req_data_valid,
  input  logic                          mem_req_data_ready,
  output logic [`MEM_DATA_BITS-1:0]     mem_req_data_bits,
  output logic [`MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                          mem_resp_valid,
  input  logic [`MEM_DATA_BITS-1:0]     mem_resp_data,
  input  logic [`MEM_TAG_BITS-1:0]      mem_resp_tag
);

  localparam int CNT_BITS = ceil_log2(DATA_CYCLES);
  localparam int TAG_W    = `MEM_TAG_BITS;

  logic [1:0]          state;
  logic [CNT_BITS-1:0] count;
  logic                owner;
  logic                last;
  logic                winner;
  logic                idle_req;
  logic                in_wdata;
  logic                addr_fire;
  logic                data_fire;
  logic                final_beat;

  mem_arb_rr2 u_rr2 (
    .valid0 (c0_req_valid),
    .valid1 (c1_req_valid),
    .last   (last),
    .grant  (winner)
  );

  // Address channel is only offered while idle; the winner's fields are muxed through.
  assign idle_req      = !reset && (state == ST_IDLE) && (c0_req_valid || c1_req_valid);
  assign mem_req_valid = idle_req;
  assign mem_req_rw    = winner ? c1_req_rw   : c0_req_rw;
  assign mem_req_addr  = winner ? c1_req_addr : c0_req_addr;
  assign mem_req_tag   = {winner, (winner ? c1_req_tag : c0_req_tag)};
  assign c0_req_ready  = idle_req && mem_req_ready && (winner == CID_ICACHE);
  assign c1_req_ready  = idle_req && mem_req_ready && (winner == CID_DCACHE);
  assign addr_fire     = idle_req && mem_req_ready;

  assign in_wdata           = !reset && (state == ST_WDATA);
  assign mem_req_data_valid = in_wdata && (owner ? c1_req_data_valid : c0_req_data_valid);
  assign mem_req_data_bits  = owner ? c1_req_data_bits : c0_req_data_bits;
  assign mem_req_data_mask  = owner ? c1_req_data_mask : c0_req_data_mask;
  assign c0_req_data_ready  = in_wdata && (owner == CID_ICACHE) && mem_req_data_ready;
  assign c1_req_data_ready  = in_wdata && (owner == CID_DCACHE) && mem_req_data_ready;
  assign data_fire          = mem_req_data_valid && mem_req_data_ready;

  assign final_beat = mem_resp_valid && (count == CNT_BITS'(DATA_CYCLES - 1));

  // Read beats are steered in every state, so stale beats still reach their owner.
  assign c0_resp_valid = !reset && mem_resp_valid && (mem_resp_tag[TAG_W-1] == CID_ICACHE);
  assign c1_resp_valid = !reset && mem_resp_valid && (mem_resp_tag[TAG_W-1] == CID_DCACHE);
  assign c0_resp_data  = mem_resp_data;
  assign c1_resp_data  = mem_resp_data;
  assign c0_resp_tag   = mem_resp_tag[TAG_W-2:0];
  assign c1_resp_tag   = mem_resp_tag[TAG_W-2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (addr_fire) begin
            owner <= winner;
            last  <= winner;
            count <= '0;
            state <= mem_req_rw ? ST_WDATA : ST_RD;
          end
        end
        ST_WDATA: begin
          if (data_fire)
            state <= ST_IDLE;
        end
        ST_RD: begin
          if (mem_resp_valid) begin
            count <= final_beat ? '0 : count + CNT_BITS'(1);
            if (final_beat)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of read arbitration vectors, a
// response scoreboard, and hand sequences for write, stall and mid-burst reset.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module tb_mem_arbiter;

  localparam int AB = `MEM_ADDR_BITS;
  localparam int DB = `MEM_DATA_BITS;
  localparam int MB = `MEM_DATA_BITS / 8;
  localparam int TW = `MEM_TAG_BITS;
  localparam int CT = `MEM_TAG_BITS - 1;
  localparam int DATA_CYCLES = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic FP = 1'b1;
`else
  localparam logic FP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic          c0_req_valid = 0, c0_req_ready, c0_req_rw = 0;
  logic [AB-1:0] c0_req_addr = '0;
  logic [CT-1:0] c0_req_tag = '0;
  logic          c0_req_data_valid = 0, c0_req_data_ready;
  logic [DB-1:0] c0_req_data_bits = '0;
  logic [MB-1:0] c0_req_data_mask = '0;
  logic          c0_resp_valid;
  logic [DB-1:0] c0_resp_data;
  logic [CT-1:0] c0_resp_tag;

  logic          c1_req_valid = 0, c1_req_ready, c1_req_rw = 0;
  logic [AB-1:0] c1_req_addr = '0;
  logic [CT-1:0] c1_req_tag = '0;
  logic          c1_req_data_valid = 0, c1_req_data_ready;
  logic [DB-1:0] c1_req_data_bits = '0;
  logic [MB-1:0] c1_req_data_mask = '0;
  logic          c1_resp_valid;
  logic [DB-1:0] c1_resp_data;
  logic [CT-1:0] c1_resp_tag;

  logic          mem_req_valid, mem_req_ready = 0, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready = 0;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid = 0;
  logic [DB-1:0] mem_resp_data = '0;
  logic [TW-1:0] mem_resp_tag = '0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          c0v;
    logic          c1v;
    logic [AB-1:0] a0;
    logic [AB-1:0] a1;
    logic [CT-1:0] t0;
    logic [CT-1:0] t1;
    logic          exp_cid;
  } vec_t;

  typedef struct {
    logic          cid;
    logic [CT-1:0] tag;
    logic [DB-1:0] data;
  } beat_t;

  beat_t sb_q[$];
  beat_t mon_exp;
  vec_t  vecs[7];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_rw(c0_req_rw),
    .c0_req_addr(c0_req_addr), .c0_req_tag(c0_req_tag),
    .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
    .c0_req_data_bits(c0_req_data_bits), .c0_req_data_mask(c0_req_data_mask),
    .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data), .c0_resp_tag(c0_resp_tag),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_rw(c1_req_rw),
    .c1_req_addr(c1_req_addr), .c1_req_tag(c1_req_tag),
    .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
    .c1_req_data_bits(c1_req_data_bits), .c1_req_data_mask(c1_req_data_mask),
    .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data), .c1_resp_tag(c1_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c0v, input logic c1v, input int a0, input int a1,
                              input int t0, input int t1, input logic exp_cid);
    vec_t v;
    v.c0v = c0v;  v.c1v = c1v;
    v.a0 = AB'(a0); v.a1 = AB'(a1);
    v.t0 = CT'(t0); v.t1 = CT'(t1);
    v.exp_cid = exp_cid;
    return v;
  endfunction

  // Response scoreboard: every driven beat was queued with its intended client.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_resp_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL resp_unexpected: got beat, expected none queued");
        end else begin
          mon_exp = sb_q.pop_front();
          check_output("resp_c0_valid", DB'(c0_resp_valid), DB'(mon_exp.cid == 1'b0));
          check_output("resp_c1_valid", DB'(c1_resp_valid), DB'(mon_exp.cid == 1'b1));
          check_output("resp_tag", DB'(mon_exp.cid ? c1_resp_tag : c0_resp_tag), DB'(mon_exp.tag));
          check_output("resp_data", mon_exp.cid ? c1_resp_data : c0_resp_data, mon_exp.data);
        end
      end else begin
        check_output("resp_idle", DB'({c0_resp_valid, c1_resp_valid}), DB'(2'b00));
      end
    end
  end

  // Drives n memory read beats on consecutive cycles, queueing each expectation.
  task automatic send_beats(input logic cid, input logic [CT-1:0] ctag, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      b.cid  = cid;
      b.tag  = ctag;
      b.data = DB'({$urandom, $urandom, $urandom, $urandom});
      mem_resp_valid = 1'b1;
      mem_resp_tag   = {cid, ctag};
      mem_resp_data  = b.data;
      sb_q.push_back(b);
    end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
  endtask

  // One read transaction: optional stall, grant check, full burst, back-to-back check.
  task automatic apply_stimulus(input vec_t v, input int stall);
    logic [CT-1:0] etag;
    logic [AB-1:0] eaddr;
    etag  = v.exp_cid ? v.t1 : v.t0;
    eaddr = v.exp_cid ? v.a1 : v.a0;
    c0_req_valid = v.c0v; c0_req_rw = 1'b0; c0_req_addr = v.a0; c0_req_tag = v.t0;
    c1_req_valid = v.c1v; c1_req_rw = 1'b0; c1_req_addr = v.a1; c1_req_tag = v.t1;
    mem_req_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_output("stall_req_valid", DB'(mem_req_valid), DB'(1'b1));
      check_output("stall_addr", DB'(mem_req_addr), DB'(eaddr));
      check_output("stall_tag", DB'(mem_req_tag), DB'({v.exp_cid, etag}));
      check_output("stall_ready", DB'({c0_req_ready, c1_req_ready}), DB'(2'b00));
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_output("req_valid", DB'(mem_req_valid), DB'(1'b1));
    check_output("req_rw", DB'(mem_req_rw), DB'(1'b0));
    check_output("req_addr", DB'(mem_req_addr), DB'(eaddr));
    check_output("req_tag", DB'(mem_req_tag), DB'({v.exp_cid, etag}));
    check_output("c0_req_ready", DB'(c0_req_ready), DB'(v.exp_cid == 1'b0));
    check_output("c1_req_ready", DB'(c1_req_ready), DB'(v.exp_cid == 1'b1));
    @(posedge clk); #1;
    if (v.exp_cid) c1_req_valid = 1'b0;
    else           c0_req_valid = 1'b0;
    @(negedge clk);
    check_output("busy_req_valid", DB'(mem_req_valid), DB'(1'b0));
    send_beats(v.exp_cid, etag, DATA_CYCLES);
    @(negedge clk);
    check_output("b2b_req_valid", DB'(mem_req_valid), DB'(v.exp_cid ? v.c0v : v.c1v));
    mem_req_ready = 1'b0;
    c0_req_valid  = 1'b0;
    c1_req_valid  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DB-1:0] wdata;
    beat_t stale;
    wdata = DB'(128'h0123456789ABCDEF0123456789ABCDEF);

    vecs[0] = mk(1'b1, 1'b1, 'h40, 'h80, 5, 3, FP);
    vecs[1] = mk(1'b1, 1'b1, 'h44, 'h84, 6, 4, 1'b1);
    vecs[2] = mk(1'b1, 1'b1, 'h48, 'h88, 7, 2, FP);
    vecs[3] = mk(1'b1, 1'b0, 'h40, 'h00, 5, 0, 1'b0);
    vecs[4] = mk(1'b1, 1'b1, 'h4C, 'h8C, 1, 9, 1'b1);
    vecs[5] = mk(1'b0, 1'b1, 'h00, 'h90, 0, 10, 1'b1);
    vecs[6] = mk(1'b1, 1'b1, 'h50, 'h94, 0, 15, FP);

    // Power-on reset with live inputs: every handshake output must stay low.
    reset = 1'b1;
    c0_req_valid = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    @(negedge clk);
    check_output("por_req_valid", DB'(mem_req_valid), DB'(1'b0));
    check_output("por_req_ready", DB'(c0_req_ready), DB'(1'b0));
    check_output("por_resp_valid", DB'(c0_resp_valid), DB'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    c0_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      apply_stimulus(vecs[i], 0);

    // dcache write; data offered in IDLE must not leak, c0 data never accepted.
    c1_req_valid = 1'b1; c1_req_rw = 1'b1; c1_req_addr = AB'('h100); c1_req_tag = CT'(7);
    c1_req_data_valid = 1'b1; c1_req_data_bits = wdata; c1_req_data_mask = MB'('h00FF);
    c0_req_data_valid = 1'b1; c0_req_data_bits = ~wdata; c0_req_data_mask = '1;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    @(negedge clk);
    check_output("wr_req_valid", DB'(mem_req_valid), DB'(1'b1));
    check_output("wr_req_rw", DB'(mem_req_rw), DB'(1'b1));
    check_output("wr_req_tag", DB'(mem_req_tag), DB'({1'b1, CT'(7)}));
    check_output("wr_req_addr", DB'(mem_req_addr), DB'('h100));
    check_output("wr_idle_data_valid", DB'(mem_req_data_valid), DB'(1'b0));
    check_output("wr_idle_data_ready", DB'({c0_req_data_ready, c1_req_data_ready}), DB'(2'b00));
    @(posedge clk); #1;
    c1_req_valid = 1'b0; mem_req_data_ready = 1'b0;
    @(negedge clk);
    check_output("wr_data_valid", DB'(mem_req_data_valid), DB'(1'b1));
    check_output("wr_data_bits", mem_req_data_bits, wdata);
    check_output("wr_data_mask", DB'(mem_req_data_mask), DB'('h00FF));
    check_output("wr_held_data_ready", DB'({c0_req_data_ready, c1_req_data_ready}), DB'(2'b00));
    check_output("wr_busy_req_valid", DB'(mem_req_valid), DB'(1'b0));
    mem_req_data_ready = 1'b1;
    #1;
    check_output("wr_c1_data_ready", DB'(c1_req_data_ready), DB'(1'b1));
    check_output("wr_c0_data_ready", DB'(c0_req_data_ready), DB'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    check_output("wr_done_data_valid", DB'(mem_req_data_valid), DB'(1'b0));
    check_output("wr_done_data_ready", DB'(c1_req_data_ready), DB'(1'b0));
    c0_req_data_valid = 1'b0; c1_req_data_valid = 1'b0; c1_req_rw = 1'b0;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;

    // Both valid behind a 3-cycle memory stall; the dcache won the last handshake.
    apply_stimulus(mk(1'b1, 1'b1, 'h200, 'h300, 1, 2, FP), 3);

    // icache read interrupted by reset after its second beat.
    c0_req_valid = 1'b1; c0_req_addr = AB'('h400); c0_req_tag = CT'(2); mem_req_ready = 1'b1;
    @(negedge clk);
    check_output("rst_c0_req_ready", DB'(c0_req_ready), DB'(1'b1));
    @(posedge clk); #1;
    c0_req_valid = 1'b0;
    send_beats(1'b0, CT'(2), 2);
    reset = 1'b1;
    c1_req_valid = 1'b1; c1_req_rw = 1'b0; c1_req_addr = AB'('h500); c1_req_tag = CT'(6);
    c1_req_data_valid = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = {1'b0, CT'(2)};
    @(negedge clk);
    check_output("rst_req_valid", DB'(mem_req_valid), DB'(1'b0));
    check_output("rst_req_ready", DB'({c0_req_ready, c1_req_ready}), DB'(2'b00));
    check_output("rst_data_valid", DB'(mem_req_data_valid), DB'(1'b0));
    check_output("rst_data_ready", DB'({c0_req_data_ready, c1_req_data_ready}), DB'(2'b00));
    check_output("rst_resp_valid", DB'({c0_resp_valid, c1_resp_valid}), DB'(2'b00));
    @(posedge clk); #1;
    reset = 1'b0;
    c1_req_data_valid = 1'b0;
    stale.cid = 1'b0; stale.tag = CT'(2); stale.data = DB'({$urandom, $urandom, $urandom, $urandom});
    mem_resp_data = stale.data;
    sb_q.push_back(stale);
    @(negedge clk);
    check_output("post_rst_req_valid", DB'(mem_req_valid), DB'(1'b1));
    check_output("post_rst_c1_ready", DB'(c1_req_ready), DB'(1'b1));
    check_output("post_rst_tag", DB'(mem_req_tag), DB'({1'b1, CT'(6)}));
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    c1_req_valid = 1'b0;
    send_beats(1'b1, CT'(6), DATA_CYCLES);
    c0_req_valid = 1'b1; c0_req_addr = AB'('h600); mem_req_ready = 1'b0;
    @(negedge clk);
    check_output("post_rst_idle", DB'(mem_req_valid), DB'(1'b1));
    c0_req_valid = 1'b0;
    @(posedge clk); #1;

    check_output("sb_drained", DB'(sb_q.size()), DB'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
